// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared constants for the SPI command sequencer: core register map, default widths
// and the FSM state encoding (also used by the bench for state checks).
package spi_cmd_sequencer_pkg;

    localparam int SPI_DATA_W = 32;
    localparam int SPI_ADDR_W = 3;

    localparam logic [SPI_ADDR_W-1:0] SPI_RX         = 3'd0;
    localparam logic [SPI_ADDR_W-1:0] SPI_TX         = 3'd1;
    localparam logic [SPI_ADDR_W-1:0] SPI_READY      = 3'd2;
    localparam logic [SPI_ADDR_W-1:0] SPI_INTRRPT_EN = 3'd3;

    localparam int SEQ_TIMER_W = 16;

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_INIT_EN = 4'd1,
        ST_IDLE    = 4'd2,
        ST_WR_TX   = 4'd3,
        ST_GAP     = 4'd4,
        ST_WAIT    = 4'd5,
        ST_RD_RX   = 4'd6,
        ST_CAPT    = 4'd7,
        ST_RSP     = 4'd8
    } seq_state_t;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Command/response streams plus the SPI core control port, seen from the sequencer
// (master) and from the environment that feeds it and models the core (slave).
interface spi_cmd_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic              sel;
    logic              read;
    logic              write;
    logic              interrupt;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready, data_in, interrupt,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, address, data_out, sel, read, write
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready, data_in, interrupt,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, address, data_out, sel, read, write
    );
endinterface

// File: rtl/spi_cmd_sequencer_timer.sv
// Saturating wait-cycle timer for the sequencer; done flags that the count equals TIMEOUT.
module spi_seq_timer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    output logic [SEQ_TIMER_W-1:0] count,
    output logic                   done
);

    // Holds at all-ones rather than wrapping, so a long wait can never look fresh again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {SEQ_TIMER_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == SEQ_TIMER_W'(TIMEOUT));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Hardware initiator for the SPI core: writes a command word to SPI_TX, waits for the
// core to finish (poll or interrupt), reads SPI_RX and returns the word on a response stream.
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int ADDR_W   = SPI_ADDR_W,
    parameter bit USE_INTR = 1'b0,
    parameter int TIMEOUT  = 65535
) (
    input logic                  clk,
    input logic                  rst,
    spi_cmd_sequencer_if.master  bus
);

    seq_state_t             state;
    logic [SEQ_TIMER_W-1:0] timer_count;
    logic                   timer_done;
    logic                   ready_seen;

    spi_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_GAP),
        .enable (state == ST_WAIT),
        .count  (timer_count),
        .done   (timer_done)
    );

    // The first WAIT cycle (count still 0) carries no read data yet, so polling skips it.
    assign ready_seen   = USE_INTR ? bus.interrupt
                                   : ((timer_count != '0) && (bus.data_in != '0));
    assign bus.cmd_ready = (state == ST_IDLE);

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_INIT;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.address   <= '0;
            bus.data_out  <= '0;
            bus.sel       <= 1'b0;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (USE_INTR) begin
                        bus.sel      <= 1'b1;
                        bus.write    <= 1'b1;
                        bus.address  <= ADDR_W'(SPI_INTRRPT_EN);
                        bus.data_out <= DATA_W'(1);
                        state        <= ST_INIT_EN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_INIT_EN: begin
                    bus.sel   <= 1'b0;
                    bus.write <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.sel      <= 1'b1;
                        bus.write    <= 1'b1;
                        bus.address  <= ADDR_W'(SPI_TX);
                        bus.data_out <= bus.cmd_data;
                        state        <= ST_WR_TX;
                    end
                end
                ST_WR_TX: begin
                    bus.sel   <= 1'b0;
                    bus.write <= 1'b0;
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    if (!USE_INTR) begin
                        bus.sel     <= 1'b1;
                        bus.read    <= 1'b1;
                        bus.address <= ADDR_W'(SPI_READY);
                    end
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ready_seen) begin
                        bus.sel     <= 1'b1;
                        bus.read    <= 1'b1;
                        bus.address <= ADDR_W'(SPI_RX);
                        state       <= ST_RD_RX;
                    end else if (timer_done) begin
                        bus.sel       <= 1'b0;
                        bus.read      <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_data  <= '0;
                        state         <= ST_RSP;
                    end
                end
                ST_RD_RX: begin
                    bus.sel  <= 1'b0;
                    bus.read <= 1'b0;
                    state    <= ST_CAPT;
                end
                ST_CAPT: begin
                    bus.rsp_data  <= bus.data_in;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RSP;
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench: a polling and an interrupt-driven sequencer, each against a small
// behavioural SPI core stub that echoes the previously transmitted word on SPI_RX.
module tb_spi_cmd_sequencer;
    import spi_cmd_sequencer_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) p_bus ();
    spi_cmd_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) i_bus ();

    spi_cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .USE_INTR(1'b0), .TIMEOUT(TMO)) p_dut (
        .clk (clk), .rst (rst), .bus (p_bus)
    );
    spi_cmd_sequencer #(.DATA_W(DW), .ADDR_W(AW), .USE_INTR(1'b1), .TIMEOUT(TMO)) i_dut (
        .clk (clk), .rst (rst), .bus (i_bus)
    );

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;
    rsp_t exp_q[$];

    // Polling core stub: READY rises p_delay cycles after a TX write unless stalled
    int            p_delay = 2;
    bit            p_stall = 1'b0;
    int            p_cnt;
    logic          p_ready;
    logic [DW-1:0] p_prev_tx, p_rx_word;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_ready       <= 1'b0;
            p_cnt         <= 0;
            p_prev_tx     <= '0;
            p_rx_word     <= '0;
            p_bus.data_in <= '0;
        end else begin
            p_bus.data_in <= '0;
            if (p_bus.sel && p_bus.read && p_bus.address == SPI_READY)
                p_bus.data_in <= {{(DW-1){1'b0}}, p_ready};
            if (p_bus.sel && p_bus.read && p_bus.address == SPI_RX)
                p_bus.data_in <= p_rx_word;
            if (p_cnt == 1) p_ready <= 1'b1;
            if (p_cnt > 0) p_cnt <= p_cnt - 1;
            if (p_bus.sel && p_bus.write && p_bus.address == SPI_TX) begin
                p_rx_word <= p_prev_tx;
                p_prev_tx <= p_bus.data_out;
                p_cnt     <= p_stall ? 0 : p_delay;
            end
            if (p_bus.sel && p_bus.read && p_bus.address == SPI_RX) p_ready <= 1'b0;
        end
    end

    // Bus trace of the polling DUT, kept as running totals
    int            tx_wr_cnt = 0, rx_rd_cnt = 0, rdy_rd_cnt = 0, gap_bad_cnt = 0, wait_cyc_cnt = 0;
    logic [DW-1:0] last_tx = '0;
    bit            prev_tx_wr = 1'b0;

    always @(posedge clk) begin
        prev_tx_wr <= p_bus.sel && p_bus.write && p_bus.address == SPI_TX;
        if (p_bus.sel && p_bus.write && p_bus.address == SPI_TX) begin
            tx_wr_cnt <= tx_wr_cnt + 1;
            last_tx   <= p_bus.data_out;
        end
        if (p_bus.sel && p_bus.read && p_bus.address == SPI_RX) rx_rd_cnt <= rx_rd_cnt + 1;
        if (p_bus.sel && p_bus.read && p_bus.address == SPI_READY) rdy_rd_cnt <= rdy_rd_cnt + 1;
        if (prev_tx_wr && (p_bus.sel || p_bus.read || p_bus.write)) gap_bad_cnt <= gap_bad_cnt + 1;
        if (p_dut.state == ST_WAIT) wait_cyc_cnt <= wait_cyc_cnt + 1;
    end

    // Interrupt core stub: interrupt only fires once the enable register was written with 1
    int            i_cnt;
    bit            i_en;
    logic [DW-1:0] i_prev_tx, i_rx_word;
    int            en_wr_cnt, en_before_rdy;
    bit            seen_rdy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cnt           <= 0;
            i_en            <= 1'b0;
            i_prev_tx       <= '0;
            i_rx_word       <= '0;
            i_bus.data_in   <= '0;
            i_bus.interrupt <= 1'b0;
            en_wr_cnt       <= 0;
            en_before_rdy   <= -1;
            seen_rdy        <= 1'b0;
        end else begin
            i_bus.data_in <= '0;
            if (i_cnt == 1 && i_en) i_bus.interrupt <= 1'b1;
            if (i_cnt > 0) i_cnt <= i_cnt - 1;
            if (i_bus.sel && i_bus.read && i_bus.address == SPI_RX) begin
                i_bus.data_in   <= i_rx_word;
                i_bus.interrupt <= 1'b0;
            end
            if (i_bus.sel && i_bus.write && i_bus.address == SPI_TX) begin
                i_rx_word <= i_prev_tx;
                i_prev_tx <= i_bus.data_out;
                i_cnt     <= 4;
            end
            if (i_bus.sel && i_bus.write && i_bus.address == SPI_INTRRPT_EN && i_bus.data_out == 1) begin
                en_wr_cnt <= en_wr_cnt + 1;
                i_en      <= 1'b1;
            end
            if (i_bus.cmd_ready && !seen_rdy) begin
                seen_rdy      <= 1'b1;
                en_before_rdy <= en_wr_cnt;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit use_i, input logic [DW-1:0] word,
                                 input logic [DW-1:0] exp_data, input logic exp_err);
        int   n = 0;
        rsp_t r;
        @(negedge clk);
        while (!(use_i ? i_bus.cmd_ready : p_bus.cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_wait", 64'(n < 100), 64'd1);
        if (use_i) begin
            i_bus.cmd_valid = 1'b1;
            i_bus.cmd_data  = word;
        end else begin
            p_bus.cmd_valid = 1'b1;
            p_bus.cmd_data  = word;
        end
        r.data = exp_data;
        r.err  = exp_err;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        i_bus.cmd_valid = 1'b0;
        p_bus.cmd_valid = 1'b0;
    endtask

    task automatic collectResponse(input bit use_i, input int hold);
        int            n = 0;
        int            viol = 0;
        logic [DW-1:0] d0;
        logic          e0;
        rsp_t          r;
        @(negedge clk);
        while (!(use_i ? i_bus.rsp_valid : p_bus.rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_valid_wait", 64'(n < 200), 64'd1);
        if (n >= 200) return;
        d0 = use_i ? i_bus.rsp_data : p_bus.rsp_data;
        e0 = use_i ? i_bus.rsp_err : p_bus.rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (use_i ? (!i_bus.rsp_valid || i_bus.cmd_ready || i_bus.rsp_data !== d0 || i_bus.rsp_err !== e0)
                      : (!p_bus.rsp_valid || p_bus.cmd_ready || p_bus.rsp_data !== d0 || p_bus.rsp_err !== e0))
                viol++;
        end
        if (hold > 0) checkOutput("rsp_hold_stable", 64'(viol), 64'd0);
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            r = exp_q.pop_front();
            checkOutput("rsp_data", 64'(d0), 64'(r.data));
            checkOutput("rsp_err", 64'(e0), 64'(r.err));
        end
        if (use_i) i_bus.rsp_ready = 1'b1; else p_bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_bus.rsp_ready = 1'b0;
        p_bus.rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("rsp_valid_drop", 64'(use_i ? i_bus.rsp_valid : p_bus.rsp_valid), 64'd0);
    endtask

    int snap_tx, snap_rx, snap_rdy, snap_gap, snap_wait;

    task automatic snapTrace();
        snap_tx   = tx_wr_cnt;
        snap_rx   = rx_rd_cnt;
        snap_rdy  = rdy_rd_cnt;
        snap_gap  = gap_bad_cnt;
        snap_wait = wait_cyc_cnt;
    endtask

    task automatic checkTrace(input logic [DW-1:0] word, input bit timed_out);
        checkOutput("trace_tx_writes", 64'(tx_wr_cnt - snap_tx), 64'd1);
        checkOutput("trace_tx_word", 64'(last_tx), 64'(word));
        checkOutput("trace_gap_idle", 64'(gap_bad_cnt - snap_gap), 64'd0);
        checkOutput("trace_ready_polls", 64'((rdy_rd_cnt - snap_rdy) >= 2), 64'd1);
        checkOutput("trace_rx_reads", 64'(rx_rd_cnt - snap_rx), timed_out ? 64'd0 : 64'd1);
        if (timed_out)
            checkOutput("timeout_wait_cycles",
                        64'((wait_cyc_cnt - snap_wait) >= TMO && (wait_cyc_cnt - snap_wait) <= TMO + 1), 64'd1);
    endtask

    logic [DW-1:0] p_model_prev;
    logic [DW-1:0] w;
    int            n;

    initial begin
        p_bus.cmd_valid = 1'b0; p_bus.cmd_data = '0; p_bus.rsp_ready = 1'b0; p_bus.interrupt = 1'b0;
        i_bus.cmd_valid = 1'b0; i_bus.cmd_data = '0; i_bus.rsp_ready = 1'b0;
        p_model_prev = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_p_ctrl", 64'({p_bus.cmd_ready, p_bus.rsp_valid, p_bus.rsp_err,
                                         p_bus.sel, p_bus.read, p_bus.write}), 64'd0);
        checkOutput("reset_p_addr_data", 64'({p_bus.address, p_bus.data_out, p_bus.rsp_data}), 64'd0);
        checkOutput("reset_i_ctrl", 64'({i_bus.cmd_ready, i_bus.rsp_valid, i_bus.rsp_err,
                                         i_bus.sel, i_bus.read, i_bus.write}), 64'd0);
        rst = 1'b1;

        // Interrupt-driven instance: enable write precedes cmd_ready, then echo round trip
        applyStimulus(1'b1, 32'hABABABAB, 32'h0, 1'b0);
        checkOutput("intr_en_before_ready", 64'(en_before_rdy), 64'd1);
        collectResponse(1'b1, 0);
        applyStimulus(1'b1, 32'h00000000, 32'hABABABAB, 1'b0);
        collectResponse(1'b1, 0);
        checkOutput("intr_en_total", 64'(en_wr_cnt), 64'd1);

        // Polling instance: two-command loopback with bus-trace checks
        p_delay = 3;
        snapTrace();
        applyStimulus(1'b0, 32'hF0F0F0F0, p_model_prev, 1'b0);
        p_model_prev = 32'hF0F0F0F0;
        collectResponse(1'b0, 0);
        checkTrace(32'hF0F0F0F0, 1'b0);
        snapTrace();
        applyStimulus(1'b0, 32'h00000000, p_model_prev, 1'b0);
        p_model_prev = 32'h00000000;
        collectResponse(1'b0, 0);
        checkTrace(32'h00000000, 1'b0);

        // Response back-pressure for 50 cycles
        applyStimulus(1'b0, 32'h12345678, p_model_prev, 1'b0);
        p_model_prev = 32'h12345678;
        collectResponse(1'b0, 50);

        // Randomised words and ready delays, best case included
        for (int k = 0; k < 4; k++) begin
            w       = $urandom;
            p_delay = (k == 0) ? 1 : int'($urandom_range(1, 8));
            snapTrace();
            applyStimulus(1'b0, w, p_model_prev, 1'b0);
            p_model_prev = w;
            collectResponse(1'b0, 0);
            checkTrace(w, 1'b0);
        end

        // Core never reports ready: timeout abort with zero data and no RX access
        p_stall = 1'b1;
        snapTrace();
        applyStimulus(1'b0, 32'hDEADBEEF, 32'h0, 1'b1);
        p_model_prev = 32'hDEADBEEF;
        collectResponse(1'b0, 0);
        checkTrace(32'hDEADBEEF, 1'b1);

        // Reset while waiting: strobes drop at once, restart and complete a fresh command
        applyStimulus(1'b0, 32'h5A5A5A5A, 32'h0, 1'b1);
        n = 0;
        while (p_dut.state != ST_WAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_wait", 64'(n < 50), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("async_reset_strobes", 64'({p_bus.sel, p_bus.read, p_bus.write, p_bus.rsp_valid}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        p_stall      = 1'b0;
        p_delay      = 2;
        p_model_prev = '0;
        applyStimulus(1'b0, 32'h13579BDF, p_model_prev, 1'b0);
        p_model_prev = 32'h13579BDF;
        collectResponse(1'b0, 0);
        applyStimulus(1'b0, 32'h2468ACE0, p_model_prev, 1'b0);
        p_model_prev = 32'h2468ACE0;
        collectResponse(1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
